mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences one transaction at a time through a request/ready/rvalid bus.
- Returns the read data and a one-cycle ack to the owning stage.
- Drives stall requests that the hazard logic ORs into its PC, IF/ID and pipeline stall terms.
- A branch flush can abort an in-flight fetch; its response is then discarded.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single unified memory port between the IF stage (instruction
// fetch) and the MEM stage (load/store). One transaction at a time is
// sequenced over a request/ready/rvalid bus. The owning stage gets its read
// data together with a one-cycle ack. Stall requests are raised to the
// hazard logic while a stage is waiting. A branch flush can abort an
// in-flight fetch; the bus transaction still completes, but its response
// produces no ack.
//
// Ports:
//   i_clk, i_reset        clock (rising edge) / async active-low reset
//   i_if_req/addr/abort   fetch request, address, branch-flush abort
//   o_if_rdata/ack        fetched instruction + one-cycle completion pulse
//   i_mem_req/we/addr/wdata/bmask  load/store request and command
//   o_mem_rdata/ack       load data + one-cycle completion pulse
//   o_bus_req/we/addr/wdata/bmask  registered bus command
//   i_bus_ready/rvalid/rdata       bus handshake and response
//   o_if_stall, o_mem_stall        stall requests to the hazard logic

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BM_W   = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_reset,

  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_abort,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ack,

  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic [BM_W-1:0]   i_mem_bmask,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ack,

  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic [BM_W-1:0]   o_bus_bmask,
  input  logic              i_bus_ready,
  input  logic              i_bus_rvalid,
  input  logic [DATA_W-1:0] i_bus_rdata,

  output logic              o_if_stall,
  output logic              o_mem_stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } owner_t;

  state_t state;
  owner_t owner;
  logic   discard;
  logic   if_ack_q;
  logic   mem_ack_q;
  logic   if_abort_hit;

  // A flush only matters while the fetch it targets actually owns the port.
  assign if_abort_hit = i_if_abort && (owner == OWN_IF);

  // Main sequencer: grant in IDLE, hold the command until the bus accepts
  // it, wait for the response, then pulse the owner's ack for one cycle.
  // The RESP cycle never grants, so a requester cannot be re-granted in its
  // own ack cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      owner       <= OWN_NONE;
      discard     <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_bmask <= '0;
      o_if_rdata  <= '0;
      o_mem_rdata <= '0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;

      case (state)
        S_IDLE: begin
          // MEM holds the older instruction, so it wins over fetch.
          if (i_mem_req) begin
            owner       <= OWN_MEM;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_we;
            o_bus_addr  <= i_mem_addr;
            o_bus_wdata <= i_mem_wdata;
            o_bus_bmask <= i_mem_bmask;
            state       <= S_REQ;
          end else if (i_if_req && !i_if_abort) begin
            owner       <= OWN_IF;
            o_bus_req   <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= i_if_addr;
            o_bus_wdata <= '0;
            o_bus_bmask <= '1;
            state       <= S_REQ;
          end
        end

        S_REQ: begin
          if (if_abort_hit) begin
            discard <= 1'b1;
          end
          if (i_bus_ready) begin
            o_bus_req <= 1'b0;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_bus_rvalid) begin
            if (owner == OWN_IF) begin
              o_if_rdata <= i_bus_rdata;
            end else begin
              o_mem_rdata <= i_bus_rdata;
            end
            // An abort arriving together with the response still discards it.
            if (discard || if_abort_hit) begin
              discard <= 1'b0;
              owner   <= OWN_NONE;
              state   <= S_IDLE;
            end else begin
              if_ack_q  <= (owner == OWN_IF);
              mem_ack_q <= (owner == OWN_MEM);
              state     <= S_RESP;
            end
          end else if (if_abort_hit) begin
            discard <= 1'b1;
          end
        end

        S_RESP: begin
          owner <= OWN_NONE;
          state <= S_IDLE;
        end

        default: begin
          owner <= OWN_NONE;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush landing in the ack cycle must still kill the fetch ack, so the
  // registered pulse is gated by the live abort.
  assign o_if_ack  = if_ack_q && !i_if_abort;
  assign o_mem_ack = mem_ack_q;

  assign o_if_stall  = i_if_req && !o_if_ack;
  assign o_mem_stall = i_mem_req && !o_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A transaction-level reference model
// tracks the one outstanding bus transaction and predicts every output; a
// compare process checks the DUT against it on each falling clock edge.
// Directed scenarios also pin key values with hand-computed literals.

module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BM_W   = 4;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_if_req = 1'b0;
  logic [ADDR_W-1:0] i_if_addr = '0;
  logic              i_if_abort = 1'b0;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_if_ack;
  logic              i_mem_req = 1'b0;
  logic              i_mem_we = 1'b0;
  logic [ADDR_W-1:0] i_mem_addr = '0;
  logic [DATA_W-1:0] i_mem_wdata = '0;
  logic [BM_W-1:0]   i_mem_bmask = '0;
  logic [DATA_W-1:0] o_mem_rdata;
  logic              o_mem_ack;
  logic              o_bus_req;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [DATA_W-1:0] o_bus_wdata;
  logic [BM_W-1:0]   o_bus_bmask;
  logic              i_bus_ready = 1'b0;
  logic              i_bus_rvalid = 1'b0;
  logic [DATA_W-1:0] i_bus_rdata = '0;
  logic              o_if_stall;
  logic              o_mem_stall;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BM_W  (BM_W)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .i_if_abort  (i_if_abort),
    .o_if_rdata  (o_if_rdata),
    .o_if_ack    (o_if_ack),
    .i_mem_req   (i_mem_req),
    .i_mem_we    (i_mem_we),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wdata (i_mem_wdata),
    .i_mem_bmask (i_mem_bmask),
    .o_mem_rdata (o_mem_rdata),
    .o_mem_ack   (o_mem_ack),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .o_bus_bmask (o_bus_bmask),
    .i_bus_ready (i_bus_ready),
    .i_bus_rvalid(i_bus_rvalid),
    .i_bus_rdata (i_bus_rdata),
    .o_if_stall  (o_if_stall),
    .o_mem_stall (o_mem_stall)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: one record for the transaction in flight.
  // m_owner: 0 = none, 1 = IF, 2 = MEM.
  bit          m_active = 1'b0;
  bit          m_accepted = 1'b0;
  bit          m_discard = 1'b0;
  bit          m_resp = 1'b0;
  int          m_owner = 0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_wdata_known = 1'b1;
  logic [3:0]  m_bmask = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_mem_rdata = '0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on each clock edge using the inputs of the cycle
  // just ending; an asserted reset wipes the record immediately.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_active = 0; m_accepted = 0; m_discard = 0; m_resp = 0; m_owner = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_wdata_known = 1; m_bmask = '0;
      m_if_rdata = '0; m_mem_rdata = '0;
    end else if (m_resp) begin
      m_resp  = 0;
      m_owner = 0;
    end else if (!m_active) begin
      if (i_mem_req) begin
        m_active = 1; m_accepted = 0; m_owner = 2;
        m_we = i_mem_we; m_addr = i_mem_addr; m_wdata = i_mem_wdata;
        m_wdata_known = 1; m_bmask = i_mem_bmask;
      end else if (i_if_req && !i_if_abort) begin
        m_active = 1; m_accepted = 0; m_owner = 1;
        m_we = 0; m_addr = i_if_addr; m_wdata_known = 0; m_bmask = 4'hF;
      end
    end else begin
      if (i_if_abort && m_owner == 1) m_discard = 1;
      if (!m_accepted) begin
        if (i_bus_ready) m_accepted = 1;
      end else if (i_bus_rvalid) begin
        if (m_owner == 1) m_if_rdata = i_bus_rdata;
        else m_mem_rdata = i_bus_rdata;
        m_active = 0;
        if (m_discard) begin
          m_discard = 0;
          m_owner   = 0;
        end else begin
          m_resp = 1;
        end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge i_clk) begin
    logic exp_if_ack;
    logic exp_mem_ack;
    exp_if_ack  = m_resp && (m_owner == 1) && !i_if_abort;
    exp_mem_ack = m_resp && (m_owner == 2);
    check_output("bus_req", {31'd0, o_bus_req}, {31'd0, m_active && !m_accepted});
    check_output("bus_we", {31'd0, o_bus_we}, {31'd0, m_we});
    check_output("bus_addr", o_bus_addr, m_addr);
    if (m_wdata_known) check_output("bus_wdata", o_bus_wdata, m_wdata);
    check_output("bus_bmask", {28'd0, o_bus_bmask}, {28'd0, m_bmask});
    check_output("if_ack", {31'd0, o_if_ack}, {31'd0, exp_if_ack});
    check_output("mem_ack", {31'd0, o_mem_ack}, {31'd0, exp_mem_ack});
    check_output("if_rdata", o_if_rdata, m_if_rdata);
    check_output("mem_rdata", o_mem_rdata, m_mem_rdata);
    check_output("if_stall", {31'd0, o_if_stall}, {31'd0, i_if_req && !exp_if_ack});
    check_output("mem_stall", {31'd0, o_mem_stall}, {31'd0, i_mem_req && !exp_mem_ack});
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic if_req, input logic [31:0] if_addr,
                                input logic if_abort, input logic mem_req,
                                input logic mem_we, input logic [31:0] mem_addr,
                                input logic [31:0] mem_wdata, input logic [3:0] mem_bmask,
                                input logic ready, input logic rvalid,
                                input logic [31:0] rdata);
    i_if_req     = if_req;
    i_if_addr    = if_addr;
    i_if_abort   = if_abort;
    i_mem_req    = mem_req;
    i_mem_we     = mem_we;
    i_mem_addr   = mem_addr;
    i_mem_wdata  = mem_wdata;
    i_mem_bmask  = mem_bmask;
    i_bus_ready  = ready;
    i_bus_rvalid = rvalid;
    i_bus_rdata  = rdata;
  endtask

  task automatic go_idle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    check_output("reset_bus_req", {31'd0, o_bus_req}, 32'd0);
    check_output("reset_if_ack", {31'd0, o_if_ack}, 32'd0);
    i_reset = 1'b1;
    step();

    // Single fetch: ack three cycles after the request.
    apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_output("t1_stall_c0", {31'd0, o_if_stall}, 32'd1);
    check_output("t1_busreq_c0", {31'd0, o_bus_req}, 32'd0);
    step(); apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 check_output("t1_busreq_c1", {31'd0, o_bus_req}, 32'd1);
    check_output("t1_addr_c1", o_bus_addr, 32'h100);
    step(); apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00A00093);
    #1 check_output("t1_busreq_c2", {31'd0, o_bus_req}, 32'd0);
    step(); apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_output("t1_ack_c3", {31'd0, o_if_ack}, 32'd1);
    check_output("t1_rdata_c3", o_if_rdata, 32'h00A00093);
    check_output("t1_stall_c3", {31'd0, o_if_stall}, 32'd0);
    step(); go_idle();
    #1 check_output("t1_ack_c4", {31'd0, o_if_ack}, 32'd0);
    step();

    // Simultaneous requests: MEM first, then IF.
    apply_stimulus(1, 32'h100, 0, 1, 0, 32'h2000, 0, 4'hF, 0, 0, 0);
    step(); apply_stimulus(1, 32'h100, 0, 1, 0, 32'h2000, 0, 4'hF, 1, 0, 0);
    #1 check_output("t2_addr_mem", o_bus_addr, 32'h2000);
    step(); apply_stimulus(1, 32'h100, 0, 1, 0, 32'h2000, 0, 4'hF, 0, 1, 32'h11111111);
    step(); apply_stimulus(1, 32'h100, 0, 1, 0, 32'h2000, 0, 4'hF, 0, 0, 0);
    #1 check_output("t2_mem_ack", {31'd0, o_mem_ack}, 32'd1);
    check_output("t2_if_ack_low", {31'd0, o_if_ack}, 32'd0);
    check_output("t2_mem_rdata", o_mem_rdata, 32'h11111111);
    step(); apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 check_output("t2_addr_if", o_bus_addr, 32'h100);
    check_output("t2_busreq_if", {31'd0, o_bus_req}, 32'd1);
    step(); apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222);
    step(); apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_output("t2_if_ack", {31'd0, o_if_ack}, 32'd1);
    step(); go_idle(); step();

    // Store with three cycles of backpressure.
    apply_stimulus(0, 0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'b0011, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); apply_stimulus(0, 0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'b0011, 0, 0, 0);
      #1 check_output("t3_wdata_hold", o_bus_wdata, 32'hDEADBEEF);
      check_output("t3_busreq_hold", {31'd0, o_bus_req}, 32'd1);
    end
    step(); apply_stimulus(0, 0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1, 0, 0);
    #1 check_output("t3_bmask", {28'd0, o_bus_bmask}, 32'h3);
    check_output("t3_we", {31'd0, o_bus_we}, 32'd1);
    step(); apply_stimulus(0, 0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'b0011, 0, 1, 32'h55AA55AA);
    step(); apply_stimulus(0, 0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'b0011, 0, 0, 0);
    #1 check_output("t3_mem_ack", {31'd0, o_mem_ack}, 32'd1);
    check_output("t3_rdata", o_mem_rdata, 32'h55AA55AA);
    step(); go_idle();
    #1 check_output("t3_ack_once", {31'd0, o_mem_ack}, 32'd0);
    step();

    // Abort in WAIT: response discarded, next fetch served normally.
    apply_stimulus(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); apply_stimulus(1, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(); apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00000BAD);
    step(); apply_stimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_output("t4_no_ack", {31'd0, o_if_ack}, 32'd0);
    step(); apply_stimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 check_output("t4_addr", o_bus_addr, 32'h200);
    step(); apply_stimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00000013);
    step(); apply_stimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_output("t4_ack", {31'd0, o_if_ack}, 32'd1);
    check_output("t4_rdata", o_if_rdata, 32'h00000013);
    step(); go_idle(); step();

    // Reset while a load waits for its response.
    apply_stimulus(0, 0, 0, 1, 0, 32'h3000, 0, 4'hF, 0, 0, 0);
    step(); apply_stimulus(0, 0, 0, 1, 0, 32'h3000, 0, 4'hF, 1, 0, 0);
    step(); go_idle();
    i_reset = 1'b0;
    #1 check_output("t5_addr_rst", o_bus_addr, 32'h0);
    check_output("t5_mem_rdata_rst", o_mem_rdata, 32'h0);
    check_output("t5_if_rdata_rst", o_if_rdata, 32'h0);
    step(); step();
    i_reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    step(); go_idle();
    #1 check_output("t5_stray_ack", {31'd0, o_mem_ack}, 32'd0);
    check_output("t5_stray_rdata", o_mem_rdata, 32'h0);
    step();
    #1 check_output("t5_stray_ack2", {31'd0, o_mem_ack}, 32'd0);

    // Back-to-back loads with IF waiting behind them.
    apply_stimulus(1, 32'h300, 0, 1, 0, 32'h2100, 0, 4'hF, 0, 0, 0);
    step(); apply_stimulus(1, 32'h300, 0, 1, 0, 32'h2100, 0, 4'hF, 1, 0, 0);
    step(); apply_stimulus(1, 32'h300, 0, 1, 0, 32'h2100, 0, 4'hF, 0, 1, 32'hA1A1A1A1);
    step(); apply_stimulus(1, 32'h300, 0, 1, 0, 32'h2100, 0, 4'hF, 0, 0, 0);
    #1 check_output("t6_ack1", {31'd0, o_mem_ack}, 32'd1);
    step(); apply_stimulus(1, 32'h300, 0, 1, 0, 32'h2104, 0, 4'hF, 0, 0, 0);
    #1 check_output("t6_gap", {31'd0, o_mem_ack}, 32'd0);
    step(); apply_stimulus(1, 32'h300, 0, 1, 0, 32'h2104, 0, 4'hF, 1, 0, 0);
    #1 check_output("t6_addr2", o_bus_addr, 32'h2104);
    step(); apply_stimulus(1, 32'h300, 0, 1, 0, 32'h2104, 0, 4'hF, 0, 1, 32'hB2B2B2B2);
    step(); apply_stimulus(1, 32'h300, 0, 1, 0, 32'h2104, 0, 4'hF, 0, 0, 0);
    #1 check_output("t6_ack2", {31'd0, o_mem_ack}, 32'd1);
    check_output("t6_rdata2", o_mem_rdata, 32'hB2B2B2B2);
    step(); apply_stimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); apply_stimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 check_output("t6_if_addr", o_bus_addr, 32'h300);
    step(); apply_stimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC3C3C3C3);
    step(); apply_stimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_output("t6_if_ack", {31'd0, o_if_ack}, 32'd1);
    step(); go_idle(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
